bcd_count_up_display: RTL

- Synchronous BCD up-counter with 74163-style controls: synchronous clear, parallel load, CEP/CET enables and a TC ripple-carry output.
- Counts from 0 up to a programmable terminal value D, then wraps to 0. It is the up-counting counterpart of the lab's loadable down-counter display.
- Count value drives an integrated 7447-style active-low seven-segment decoder with LTN/RBIN/BIN/RBON ripple blanking.
- Sits on the lab board between the 50 MHz clock and one seven-segment digit; TC cascades to the next digit.

---
 rtl/bcd_display_pkg.sv | 35 +++
 rtl/bcd_7seg_decoder.sv | 49 ++++
 rtl/bcd_count_up_display.sv | 65 ++++++
 3 files changed

// File: rtl/bcd_display_pkg.sv
// Shared constants for the lab's BCD counter / seven-segment display blocks.
// Segment vectors are {a,b,c,d,e,f,g}, active-low (0 = lit).
package bcd_display_pkg;

  // Bit position of each segment within a 7-bit segment vector.
  localparam int SEG_IDX_A = 6;
  localparam int SEG_IDX_B = 5;
  localparam int SEG_IDX_C = 4;
  localparam int SEG_IDX_D = 3;
  localparam int SEG_IDX_E = 2;
  localparam int SEG_IDX_F = 1;
  localparam int SEG_IDX_G = 0;

  localparam logic [3:0] MAX_DIGIT_DEFAULT = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;

  // Limit used by the counter: the requested value, saturated at the ceiling.
  function automatic logic [3:0] clamp_digit(input logic [3:0] value,
                                             input logic [3:0] ceiling);
    return (value > ceiling) ? ceiling : value;
  endfunction

endpackage

// File: rtl/bcd_7seg_decoder.sv
// 7447-style BCD to active-low seven-segment decoder with lamp test and
// ripple blanking; purely combinational, shared with the down-counter display.
module bcd_7seg_decoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       LTN,
  input  logic       RBIN,
  input  logic       BIN,
  output logic [6:0] o_Z,
  output logic       RBON
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (value)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
  end

  // Blanking beats lamp test, which beats ripple blanking of a leading zero.
  always_comb begin
    o_Z  = glyph;
    RBON = 1'b1;
    if (!BIN) begin
      o_Z  = SEG_BLANK;
      RBON = 1'b0;
    end else if (!LTN) begin
      o_Z  = SEG_ALL;
      RBON = 1'b1;
    end else if (!RBIN && (value == 4'd0)) begin
      o_Z  = SEG_BLANK;
      RBON = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_count_up_display.sv
// 74163-style BCD up-counter wrapping at a programmable limit, driving one
// seven-segment digit; TC cascades to the next digit.
module bcd_count_up_display
  import bcd_display_pkg::*;
#(
  parameter logic [3:0] MAX_DIGIT = MAX_DIGIT_DEFAULT
)(
  input  logic       CP,
  input  logic       rstn,
  input  logic [3:0] D,
  input  logic       PEn,
  input  logic       CEP,
  input  logic       CET,
  input  logic       MRn,
  input  logic       LTN,
  input  logic       RBIN,
  input  logic       BIN,
  output logic [3:0] Q,
  output logic       TC,
  output logic       RBON,
  output logic [6:0] o_Z
);

  // A ceiling above 9 would let the counter leave BCD range.
  localparam logic [3:0] CEILING = (MAX_DIGIT > 4'd9) ? 4'd9 : MAX_DIGIT;

  logic [3:0] limit;
  logic [3:0] q_reg;
  logic [3:0] q_next;

  assign limit = clamp_digit(D, CEILING);

  // Wrap on >= so that lowering D below the current count still wraps to 0.
  always_comb begin
    q_next = q_reg;
    if (!MRn) begin
      q_next = 4'd0;
    end else if (!PEn) begin
      q_next = limit;
    end else if (CEP && CET) begin
      q_next = (q_reg >= limit) ? 4'd0 : q_reg + 4'd1;
    end
  end

  always_ff @(posedge CP or negedge rstn) begin
    if (!rstn) begin
      q_reg <= 4'd0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q  = q_reg;
  assign TC = CET & (q_reg == limit);

  bcd_7seg_decoder u_decoder (
    .value (q_reg),
    .LTN   (LTN),
    .RBIN  (RBIN),
    .BIN   (BIN),
    .o_Z   (o_Z),
    .RBON  (RBON)
  );

endmodule
